// File: rtl/nonce_result_check.sv
// nonce_result_check
// Sits downstream of the hashing core. A valid-tagged nonce delay line, matched
// to the core latency, lines up each final_hash with the nonce that produced it.
// Every valid tap is compared against target. Each hit is queued in a small
// result FIFO, and the host drains that FIFO with a valid/ready handshake.
//
// Ports:
//   clk, rst            rising-edge clock; asynchronous active-high reset
//   issue_valid/_nonce  a message carrying issue_nonce entered the core
//   final_hash          core output, aligned with the delay-line tap
//   target              hit threshold (hit when final_hash <= target)
//   clear               synchronous flush of the delay line and the FIFO
//   found_valid/_nonce/_hash, found_ready
//                       result FIFO head and host handshake
//   checked_count       number of valid taps compared since reset (wraps)
//   drop_count          number of hits lost to a full FIFO (saturating)
//   busy                any valid delay-line entry or a non-empty FIFO
module nonce_result_check #(
  parameter int unsigned LATENCY    = 96,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CNT_W      = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_valid,
  input  logic [63:0]      issue_nonce,
  input  logic [63:0]      final_hash,
  input  logic [63:0]      target,
  input  logic             clear,
  output logic             found_valid,
  output logic [63:0]      found_nonce,
  output logic [63:0]      found_hash,
  input  logic             found_ready,
  output logic [CNT_W-1:0] checked_count,
  output logic [15:0]      drop_count,
  output logic             busy
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  typedef logic [PW-1:0] ptr_t;
  typedef logic [PW:0]   cnt_t;
  localparam cnt_t FULL_C = cnt_t'(FIFO_DEPTH);

  // ---------------- delay line ----------------
  logic [LATENCY-1:0] valid_q, valid_d;
  logic [63:0]        nonce_q [LATENCY];
  logic               tap_valid;
  logic [63:0]        tap_nonce;

  assign tap_valid = valid_q[LATENCY-1];
  assign tap_nonce = nonce_q[LATENCY-1];

  // A clear drops every in-flight tag, including one issued in the same cycle.
  always_comb begin
    valid_d = '0;
    if (!clear) begin
      valid_d    = valid_q << 1;
      valid_d[0] = issue_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) valid_q <= '0;
    else     valid_q <= valid_d;
  end

  // Nonce payloads are qualified by valid_q, so they need no reset.
  always_ff @(posedge clk) begin
    nonce_q[0] <= issue_nonce;
    for (int unsigned i = 1; i < LATENCY; i++) nonce_q[i] <= nonce_q[i-1];
  end

  // ---------------- compare and FIFO control ----------------
  logic [63:0] mem_nonce_q [FIFO_DEPTH];
  logic [63:0] mem_hash_q  [FIFO_DEPTH];
  ptr_t        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  cnt_t        count_q, count_d;
  logic [63:0] found_nonce_q, found_nonce_d, found_hash_q, found_hash_d;
  logic [CNT_W-1:0] checked_q;
  logic [15:0] drop_q;
  logic        hit, full, pop, push, drop;

  assign hit  = tap_valid && (final_hash <= target);
  assign full = (count_q == FULL_C);
  assign pop  = (count_q != '0) && found_ready;
  assign push = hit && !clear && (!full || pop);
  assign drop = hit && !clear && full && !pop;

  // The head is kept in output registers so that it holds its last value once
  // the FIFO is empty. When the FIFO is empty after this edge's pop, the
  // entry being pushed goes straight into the head registers.
  always_comb begin
    rd_ptr_d      = rd_ptr_q + ptr_t'(pop);
    wr_ptr_d      = wr_ptr_q + ptr_t'(push);
    count_d       = count_q + cnt_t'(push) - cnt_t'(pop);
    found_nonce_d = found_nonce_q;
    found_hash_d  = found_hash_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (count_d != '0) begin
      if ((count_q - cnt_t'(pop)) == '0) begin
        found_nonce_d = tap_nonce;
        found_hash_d  = final_hash;
      end else begin
        found_nonce_d = mem_nonce_q[rd_ptr_d];
        found_hash_d  = mem_hash_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      found_nonce_q <= '0;
      found_hash_q  <= '0;
      checked_q     <= '0;
      drop_q        <= '0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      found_nonce_q <= found_nonce_d;
      found_hash_q  <= found_hash_d;
      if (tap_valid) checked_q <= checked_q + CNT_W'(1);
      if (drop && (drop_q != '1)) drop_q <= drop_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_nonce_q[wr_ptr_q] <= tap_nonce;
      mem_hash_q[wr_ptr_q]  <= final_hash;
    end
  end

  assign found_valid   = (count_q != '0);
  assign found_nonce   = found_nonce_q;
  assign found_hash    = found_hash_q;
  assign checked_count = checked_q;
  assign drop_count    = drop_q;
  assign busy          = (|valid_q) || (count_q != '0);

endmodule

// File: tb/tb_nonce_result_check.sv
module tb_nonce_result_check;
  localparam int unsigned LAT   = 96;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = 48;

  logic          clk, rst, issue_valid, clear, found_ready;
  logic [63:0]   issue_nonce, final_hash, target;
  logic          found_valid, busy;
  logic [63:0]   found_nonce, found_hash;
  logic [CW-1:0] checked_count;
  logic [15:0]   drop_count;

  nonce_result_check #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_nonce(issue_nonce),
    .final_hash(final_hash), .target(target), .clear(clear),
    .found_valid(found_valid), .found_nonce(found_nonce), .found_hash(found_hash),
    .found_ready(found_ready), .checked_count(checked_count),
    .drop_count(drop_count), .busy(busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [63:0]  hash_sched [int];
  logic [127:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: inputs change 1 time unit after the rising edge, and the
  // core output scheduled for the new cycle is applied at the same time.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    final_hash = hash_sched.exists(cyc) ? hash_sched[cyc] : 64'h0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  // Issue a nonce in the current cycle. The core answers LAT cycles later.
  task automatic issue(input logic [63:0] n, input logic [63:0] h, input bit exp_hit);
    issue_valid = 1'b1;
    issue_nonce = n;
    hash_sched[cyc + LAT] = h;
    if (exp_hit) exp_q.push_back({n, h});
    tick();
    issue_valid = 1'b0;
  endtask

  task automatic pop_check();
    logic [127:0] e;
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL sb_underflow observed=%0d expected=nonzero", exp_q.size());
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    chk("pop_nonce", found_nonce, e[127:64]);
    chk("pop_hash", found_hash, e[63:0]);
  endtask

  task automatic drain(input int n);
    for (int k = 0; k < n; k++) begin
      int t = 0;
      while (!found_valid && t < LAT + 20) begin tick(); t++; end
      chk("pop_valid", 64'(found_valid), 64'd1);
      pop_check();
      found_ready = 1'b1;
      tick();
      found_ready = 1'b0;
    end
  endtask

  initial begin
    int c;
    bit saw;
    rst = 1'b1; issue_valid = 1'b0; issue_nonce = '0; final_hash = '0;
    target = '0; clear = 1'b0; found_ready = 1'b0;
    #23;
    chk("rst_found_valid", 64'(found_valid), 64'd0);
    chk("rst_found_nonce", found_nonce, 64'd0);
    chk("rst_found_hash", found_hash, 64'd0);
    chk("rst_checked", 64'(checked_count), 64'd0);
    chk("rst_drop", 64'(drop_count), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    tick();
    cyc = 0;

    // Basic hit: issue at cycle 10, hash at cycle 106, found_valid at cycle 107.
    target = 64'h0000_FFFF_FFFF_FFFF;
    wait_cyc(10);
    issue(64'h1234, 64'h1, 1'b1);
    chk("busy_inflight", 64'(busy), 64'd1);
    wait_cyc(106);
    chk("basic_not_early", 64'(found_valid), 64'd0);
    tick();
    chk("basic_valid_107", 64'(found_valid), 64'd1);
    chk("basic_checked", 64'(checked_count), 64'd1);
    drain(1);
    chk("basic_idle", 64'(busy), 64'd0);

    // Miss and boundary: target+1 misses, target and 0 hit.
    target = 64'h100;
    issue(64'd1, 64'h101, 1'b0);
    issue(64'd2, 64'h100, 1'b1);
    issue(64'd3, 64'h0, 1'b1);
    repeat (LAT + 2) tick();
    chk("bound_checked", 64'(checked_count), 64'd4);
    drain(2);
    chk("bound_empty", 64'(found_valid), 64'd0);

    // Overflow: six hits into a 4-deep FIFO, then a 7th hit during a pop.
    target = '1;
    c = cyc;
    for (int i = 0; i < 6; i++) issue(64'(10 + i), 64'h5, (i < 4));
    issue(64'd16, 64'h5, 1'b1);
    wait_cyc(c + LAT + 6);
    chk("ovf_drop2", 64'(drop_count), 64'd2);
    chk("ovf_hold_nonce", found_nonce, 64'd10);
    pop_check();
    found_ready = 1'b1;
    tick();
    found_ready = 1'b0;
    chk("ovf_drop_stays", 64'(drop_count), 64'd2);
    chk("ovf_checked", 64'(checked_count), 64'd11);
    drain(4);
    chk("ovf_empty", 64'(found_valid), 64'd0);

    // Gaps: idle tap carries hash 0, which would qualify if it were compared.
    issue(64'd20, 64'h0, 1'b1);
    tick();
    issue(64'd21, 64'h0, 1'b1);
    repeat (LAT + 2) tick();
    chk("gap_checked", 64'(checked_count), 64'd13);
    drain(2);
    repeat (3) tick();
    chk("gap_no_extra", 64'(found_valid), 64'd0);

    // Clear mid-flight: four results queued (FIFO full), fifth tap coincides
    // with clear, five more nonces still in the delay line.
    c = cyc;
    for (int i = 0; i < 10; i++) issue(64'(100 + i), 64'h9, 1'b0);
    wait_cyc(c + LAT + 4);
    chk("clr_full", 64'(found_valid), 64'd1);
    clear = 1'b1;
    issue_valid = 1'b1;
    issue_nonce = 64'd999;
    hash_sched[cyc + LAT] = 64'h0;
    tick();
    clear = 1'b0;
    issue_valid = 1'b0;
    chk("clr_found_valid", 64'(found_valid), 64'd0);
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_checked", 64'(checked_count), 64'd18);
    chk("clr_no_drop", 64'(drop_count), 64'd2);
    saw = 1'b0;
    for (int i = 0; i < LAT + 10; i++) begin
      tick();
      saw = saw | found_valid | busy;
    end
    chk("clr_quiet", 64'(saw), 64'd0);
    chk("clr_checked_after", 64'(checked_count), 64'd18);

    // Async reset with three results queued and one nonce still in flight.
    c = cyc;
    issue(64'd30, 64'h1, 1'b1);
    issue(64'd31, 64'h2, 1'b1);
    issue(64'd32, 64'h3, 1'b1);
    issue(64'd33, 64'h4, 1'b0);
    wait_cyc(c + LAT + 3);
    chk("ar_queued", 64'(found_valid), 64'd1);
    chk("ar_busy_before", 64'(busy), 64'd1);
    #3 rst = 1'b1;
    #1;
    chk("ar_found_valid", 64'(found_valid), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_checked", 64'(checked_count), 64'd0);
    chk("ar_drop", 64'(drop_count), 64'd0);
    chk("ar_nonce", found_nonce, 64'd0);
    exp_q.delete();
    #1 rst = 1'b0;
    tick();
    issue(64'd40, 64'h7, 1'b1);
    drain(1);
    chk("ar_resume_checked", 64'(checked_count), 64'd1);
    chk("ar_resume_idle", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
